// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bus: decoded instruction fields from ID, registered copies
// presented to EX, plus the flush request from EX and the stall request upstream.
// master = ID/EX neighbours driving the stage; slave = the pipeline register itself.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // ID-side inputs to the register
    logic              id_valid;
    logic              id_RegWrite;
    logic              id_MemtoReg;
    logic              id_MemRead;
    logic              id_MemWrite;
    logic              id_RegDst;
    logic              id_ALUsrc;
    logic [1:0]        id_PCsrc;
    logic [4:0]        id_ALUop;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic [4:0]        id_shamt;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc4;
    logic              ex_flush;

    // EX-side registered outputs
    logic              ex_valid;
    logic              ex_RegWrite;
    logic              ex_MemtoReg;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic              ex_ALUsrc;
    logic [1:0]        ex_PCsrc;
    logic [4:0]        ex_ALUop;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic [REG_W-1:0]  ex_dest;
    logic [4:0]        ex_shamt;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc4;
    logic              hazard_stall;

    modport master (
        output id_valid, id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite,
               id_RegDst, id_ALUsrc, id_PCsrc, id_ALUop, id_rs, id_rt, id_rd,
               id_shamt, id_rdata1, id_rdata2, id_imm, id_pc4, ex_flush,
        input  ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite,
               ex_ALUsrc, ex_PCsrc, ex_ALUop, ex_rs, ex_rt, ex_rd, ex_dest,
               ex_shamt, ex_rdata1, ex_rdata2, ex_imm, ex_pc4, hazard_stall
    );

    modport slave (
        input  id_valid, id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite,
               id_RegDst, id_ALUsrc, id_PCsrc, id_ALUop, id_rs, id_rt, id_rd,
               id_shamt, id_rdata1, id_rdata2, id_imm, id_pc4, ex_flush,
        output ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite,
               ex_ALUsrc, ex_PCsrc, ex_ALUop, ex_rs, ex_rt, ex_rd, ex_dest,
               ex_shamt, ex_rdata1, ex_rdata2, ex_imm, ex_pc4, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and branch flush.
// A flush or a load-use stall loads an all-zero bubble; otherwise the ID
// instruction is captured, with its control bits zeroed when id_valid is low.
// Optional macro ID_EX_PERF_CNT_EN adds stall/flush event counters.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic clk,
    input  logic rst,
    id_ex_stage_reg_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic              RegWrite;
        logic              MemtoReg;
        logic              MemRead;
        logic              MemWrite;
        logic              ALUsrc;
        logic [1:0]        PCsrc;
        logic [4:0]        ALUop;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  dest;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
    } ex_bundle_t;

    ex_bundle_t bundle_reg;
    ex_bundle_t bundle_next;
    logic       uses_rt;
    logic       hazard_stall;

    // Load-use detector: looks only at the current EX contents and the ID instruction.
    // While rst is high the EX register is zero, so ex_valid gates the stall off.
    always_comb begin
        uses_rt      = ~bus.id_ALUsrc | bus.id_MemWrite | (bus.id_PCsrc == 2'b10);
        hazard_stall = bundle_reg.valid & bundle_reg.MemRead & bus.id_valid & ~bus.ex_flush
                     & (bundle_reg.dest != '0)
                     & ((bundle_reg.dest == bus.id_rs) | (uses_rt & (bundle_reg.dest == bus.id_rt)));
    end

    // Next EX contents: bubble on flush or stall, otherwise the ID instruction.
    always_comb begin
        bundle_next = '0;
        if (!bus.ex_flush && !hazard_stall) begin
            bundle_next.valid  = bus.id_valid;
            // An empty ID slot must not carry live control bits into EX.
            if (bus.id_valid) begin
                bundle_next.RegWrite = bus.id_RegWrite;
                bundle_next.MemtoReg = bus.id_MemtoReg;
                bundle_next.MemRead  = bus.id_MemRead;
                bundle_next.MemWrite = bus.id_MemWrite;
                bundle_next.ALUsrc   = bus.id_ALUsrc;
                bundle_next.PCsrc    = bus.id_PCsrc;
                bundle_next.ALUop    = bus.id_ALUop;
            end
            bundle_next.rs     = bus.id_rs;
            bundle_next.rt     = bus.id_rt;
            bundle_next.rd     = bus.id_rd;
            bundle_next.dest   = bus.id_RegDst ? bus.id_rt : bus.id_rd;
            bundle_next.shamt  = bus.id_shamt;
            bundle_next.rdata1 = bus.id_rdata1;
            bundle_next.rdata2 = bus.id_rdata2;
            bundle_next.imm    = bus.id_imm;
            bundle_next.pc4    = bus.id_pc4;
        end
    end

    // Pipeline register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_reg <= '0;
        end else begin
            bundle_reg <= bundle_next;
        end
    end

    assign bus.ex_valid     = bundle_reg.valid;
    assign bus.ex_RegWrite  = bundle_reg.RegWrite;
    assign bus.ex_MemtoReg  = bundle_reg.MemtoReg;
    assign bus.ex_MemRead   = bundle_reg.MemRead;
    assign bus.ex_MemWrite  = bundle_reg.MemWrite;
    assign bus.ex_ALUsrc    = bundle_reg.ALUsrc;
    assign bus.ex_PCsrc     = bundle_reg.PCsrc;
    assign bus.ex_ALUop     = bundle_reg.ALUop;
    assign bus.ex_rs        = bundle_reg.rs;
    assign bus.ex_rt        = bundle_reg.rt;
    assign bus.ex_rd        = bundle_reg.rd;
    assign bus.ex_dest      = bundle_reg.dest;
    assign bus.ex_shamt     = bundle_reg.shamt;
    assign bus.ex_rdata1    = bundle_reg.rdata1;
    assign bus.ex_rdata2    = bundle_reg.rdata2;
    assign bus.ex_imm       = bundle_reg.imm;
    assign bus.ex_pc4       = bundle_reg.pc4;
    assign bus.hazard_stall = hazard_stall;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // Event counters; free-running and wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (hazard_stall) stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (bus.ex_flush) flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_reg;
    assign perf_flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg: directed instruction sequences, an
// instruction-level reference model checked every cycle, and literal checks.
module tb_id_ex_stage_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] pc = 32'h0000_0400;

    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.DATA_W(32), .REG_W(5)) bus ();

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    id_ex_stage_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // ---------------- reference model: the instruction sitting in EX ----------------
    typedef struct packed {
        logic        valid, rw, mtr, mr, mw, alusrc;
        logic [1:0]  pcsrc;
        logic [4:0]  aluop, rs, rt, rd, dest, shamt;
        logic [31:0] d1, d2, imm, pc4;
    } instr_t;

    instr_t      in_ex;
    int unsigned m_stalls;
    int unsigned m_flushes;
    logic        m_stall_now;

    // True when the ID instruction needs a value a load in EX has not produced yet.
    function automatic logic model_hazard();
        logic reads_rt;
        logic is_load_pending;
        reads_rt        = !bus.id_ALUsrc || bus.id_MemWrite || (bus.id_PCsrc == 2'b10);
        is_load_pending = in_ex.valid && in_ex.mr && (in_ex.dest != 5'd0);
        if (!bus.id_valid || bus.ex_flush || !is_load_pending) return 1'b0;
        return (in_ex.dest == bus.id_rs) || (reads_rt && in_ex.dest == bus.id_rt);
    endfunction

    // What EX should hold after an edge that lets the ID instruction through.
    function automatic instr_t id_instruction();
        instr_t r;
        r        = '0;
        r.valid  = bus.id_valid;
        if (bus.id_valid) begin
            r.rw     = bus.id_RegWrite;
            r.mtr    = bus.id_MemtoReg;
            r.mr     = bus.id_MemRead;
            r.mw     = bus.id_MemWrite;
            r.alusrc = bus.id_ALUsrc;
            r.pcsrc  = bus.id_PCsrc;
            r.aluop  = bus.id_ALUop;
        end
        r.rs    = bus.id_rs;
        r.rt    = bus.id_rt;
        r.rd    = bus.id_rd;
        r.dest  = bus.id_RegDst ? bus.id_rt : bus.id_rd;
        r.shamt = bus.id_shamt;
        r.d1    = bus.id_rdata1;
        r.d2    = bus.id_rdata2;
        r.imm   = bus.id_imm;
        r.pc4   = bus.id_pc4;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ex     = '0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            m_stall_now = model_hazard();
            if (bus.ex_flush) m_flushes = m_flushes + 1;
            if (m_stall_now)  m_stalls  = m_stalls + 1;
            in_ex = (bus.ex_flush || m_stall_now) ? '0 : id_instruction();
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_valid",    64'(bus.ex_valid),     64'(in_ex.valid));
        chk("m_RegWrite", 64'(bus.ex_RegWrite),  64'(in_ex.rw));
        chk("m_MemtoReg", 64'(bus.ex_MemtoReg),  64'(in_ex.mtr));
        chk("m_MemRead",  64'(bus.ex_MemRead),   64'(in_ex.mr));
        chk("m_MemWrite", 64'(bus.ex_MemWrite),  64'(in_ex.mw));
        chk("m_ALUsrc",   64'(bus.ex_ALUsrc),    64'(in_ex.alusrc));
        chk("m_PCsrc",    64'(bus.ex_PCsrc),     64'(in_ex.pcsrc));
        chk("m_ALUop",    64'(bus.ex_ALUop),     64'(in_ex.aluop));
        chk("m_rs",       64'(bus.ex_rs),        64'(in_ex.rs));
        chk("m_rt",       64'(bus.ex_rt),        64'(in_ex.rt));
        chk("m_rd",       64'(bus.ex_rd),        64'(in_ex.rd));
        chk("m_dest",     64'(bus.ex_dest),      64'(in_ex.dest));
        chk("m_shamt",    64'(bus.ex_shamt),     64'(in_ex.shamt));
        chk("m_rdata1",   64'(bus.ex_rdata1),    64'(in_ex.d1));
        chk("m_rdata2",   64'(bus.ex_rdata2),    64'(in_ex.d2));
        chk("m_imm",      64'(bus.ex_imm),       64'(in_ex.imm));
        chk("m_pc4",      64'(bus.ex_pc4),       64'(in_ex.pc4));
        chk("m_stall",    64'(bus.hazard_stall), 64'(model_hazard()));
`ifdef ID_EX_PERF_CNT_EN
        chk("m_perf_stall", 64'(perf_stall_cnt), 64'(m_stalls));
        chk("m_perf_flush", 64'(perf_flush_cnt), 64'(m_flushes));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic rw, input logic mtr, input logic mr,
                       input logic mw, input logic rdst, input logic alusrc,
                       input logic [1:0] pcsrc, input logic [4:0] aluop,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] imm);
        bus.id_valid    = v;
        bus.id_RegWrite = rw;
        bus.id_MemtoReg = mtr;
        bus.id_MemRead  = mr;
        bus.id_MemWrite = mw;
        bus.id_RegDst   = rdst;
        bus.id_ALUsrc   = alusrc;
        bus.id_PCsrc    = pcsrc;
        bus.id_ALUop    = aluop;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = rd;
        bus.id_shamt    = rs ^ rd;
        bus.id_rdata1   = $urandom;
        bus.id_rdata2   = $urandom;
        bus.id_imm      = imm;
        pc              = pc + 32'd4;
        bus.id_pc4      = pc;
        #1;
    endtask

    task automatic op_nop();                                   put(0,0,0,0,0,0,0,2'b00,5'd0,5'd0,5'd0,5'd0,32'd0); endtask
    task automatic op_lw(input logic [4:0] rs, input logic [4:0] rt);  put(1,1,1,1,0,1,1,2'b00,5'd2,rs,rt,5'd0,32'd16); endtask
    task automatic op_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
                                                               put(1,1,0,0,0,1,1,2'b00,5'd2,rs,rt,5'd0,imm); endtask
    task automatic op_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
                                                               put(1,1,0,0,0,0,0,2'b00,5'd2,rs,rt,rd,32'd0); endtask
    task automatic op_sw(input logic [4:0] rs, input logic [4:0] rt);  put(1,0,0,0,1,0,1,2'b00,5'd2,rs,rt,5'd0,32'd8); endtask
    task automatic op_beq(input logic [4:0] rs, input logic [4:0] rt); put(1,0,0,0,0,0,1,2'b10,5'd6,rs,rt,5'd0,32'hFFFF_FFFC); endtask

    initial begin
        bus.ex_flush = 1'b0;
        op_nop();
        step();
        step();
        chk("rst_valid", 64'(bus.ex_valid),     64'd0);
        chk("rst_stall", 64'(bus.hazard_stall), 64'd0);
        chk("rst_pc4",   64'(bus.ex_pc4),       64'd0);
        rst = 1'b0;
        step();

        // addi $8, $0, 5
        op_addi(5'd0, 5'd8, 32'd5);
        step();
        chk("addi_dest",  64'(bus.ex_dest),  64'd8);
        chk("addi_imm",   64'(bus.ex_imm),   64'd5);
        chk("addi_valid", 64'(bus.ex_valid), 64'd1);

        // lw $9 then add $11, $9, $2: one-cycle stall then capture
        op_lw(5'd1, 5'd9);
        step();
        op_add(5'd9, 5'd2, 5'd11);
        chk("lu_stall", 64'(bus.hazard_stall), 64'd1);
        step();
        chk("lu_bubble_valid", 64'(bus.ex_valid),     64'd0);
        chk("lu_bubble_mr",    64'(bus.ex_MemRead),   64'd0);
        chk("lu_stall_drop",   64'(bus.hazard_stall), 64'd0);
        step();
        chk("lu_add_dest",  64'(bus.ex_dest),  64'd11);
        chk("lu_add_valid", 64'(bus.ex_valid), 64'd1);

        // lw $0 never stalls
        op_lw(5'd1, 5'd0);
        step();
        op_add(5'd0, 5'd0, 5'd12);
        chk("lw_r0_nostall", 64'(bus.hazard_stall), 64'd0);
        step();

        // lw $10: addi reading only rs does not stall; sw storing $10 does
        op_lw(5'd1, 5'd10);
        step();
        op_addi(5'd3, 5'd10, 32'd1);
        chk("addi_rt_nostall", 64'(bus.hazard_stall), 64'd0);
        op_sw(5'd3, 5'd10);
        chk("sw_rt_stall", 64'(bus.hazard_stall), 64'd1);
        step();
        step();

        // lw $13 then beq using rt: branch reads rt
        op_lw(5'd1, 5'd13);
        step();
        op_beq(5'd4, 5'd13);
        chk("beq_rt_stall", 64'(bus.hazard_stall), 64'd1);
        step();
        step();

        // flush wins over a load-use hazard
        op_lw(5'd1, 5'd12);
        step();
        op_add(5'd12, 5'd1, 5'd14);
        bus.ex_flush = 1'b1;
        #1;
        chk("flush_nostall", 64'(bus.hazard_stall), 64'd0);
        step();
        bus.ex_flush = 1'b0;
        chk("flush_rw",    64'(bus.ex_RegWrite), 64'd0);
        chk("flush_mw",    64'(bus.ex_MemWrite), 64'd0);
        chk("flush_valid", 64'(bus.ex_valid),    64'd0);
        step();

        // invalid ID slot carries no control bits
        put(0,1,1,1,1,1,1,2'b10,5'd9,5'd1,5'd2,5'd3,32'd7);
        step();
        chk("inv_mr",    64'(bus.ex_MemRead),  64'd0);
        chk("inv_pcsrc", 64'(bus.ex_PCsrc),    64'd0);
        chk("inv_aluop", 64'(bus.ex_ALUop),    64'd0);

        // back-to-back loads: lw $5; lw $6,($5); add uses $6
        op_lw(5'd1, 5'd5);
        step();
        op_lw(5'd5, 5'd6);
        chk("b2b_stall1", 64'(bus.hazard_stall), 64'd1);
        step();
        step();
        op_add(5'd6, 5'd0, 5'd3);
        chk("b2b_stall2", 64'(bus.hazard_stall), 64'd1);
        step();
        step();

        // reset asserted mid-stall
        op_lw(5'd1, 5'd9);
        step();
        op_add(5'd9, 5'd9, 5'd15);
        chk("mid_stall", 64'(bus.hazard_stall), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 64'(bus.hazard_stall), 64'd0);
        chk("mid_rst_valid", 64'(bus.ex_valid),     64'd0);
        step();
        rst = 1'b0;
        op_nop();
        step();

`ifdef ID_EX_PERF_CNT_EN
        // three stalls, two flushes, then reset clears both counters
        for (int i = 0; i < 3; i++) begin
            op_lw(5'd1, 5'd7);
            step();
            op_add(5'd7, 5'd0, 5'd8);
            step();
            step();
        end
        op_nop();
        for (int i = 0; i < 2; i++) begin
            bus.ex_flush = 1'b1;
            step();
            bus.ex_flush = 1'b0;
            step();
        end
        chk("perf_stall_3", 64'(perf_stall_cnt), 64'd3);
        chk("perf_flush_2", 64'(perf_flush_cnt), 64'd2);
        rst = 1'b1;
        #1;
        chk("perf_stall_rst", 64'(perf_stall_cnt), 64'd0);
        chk("perf_flush_rst", 64'(perf_flush_cnt), 64'd0);
        step();
        rst = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the five-stage processor, with a load-use hazard detector and branch flush. It captures the decoded control bundle from the controller plus operands and fields from the register file and decode logic, and presents them to the EX stage one cycle later. When a load-use hazard is detected it requests a one-cycle stall upstream and inserts a bubble. On a taken branch or jump it squashes the instruction being captured.

## Interface
Parameters:
- `DATA_W`, 32: operand, immediate and PC width.
- `REG_W`, 5: register specifier width.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `id_valid`  in  1  — the ID stage holds a real instruction.
- `id_RegWrite`, `id_MemtoReg`, `id_MemRead`, `id_MemWrite`, `id_RegDst`, `id_ALUsrc`  in  1 each  — control bits from the controller.
- `id_PCsrc`  in  2  — 00 sequential, 01 jr, 10 branch.
- `id_ALUop`  in  5  — ALU operation code.
- `id_rs`, `id_rt`, `id_rd`  in  REG_W each  — instruction register fields.
- `id_shamt`  in  5  — shift amount.
- `id_rdata1`, `id_rdata2`, `id_imm`, `id_pc4`  in  DATA_W each  — register-file reads, sign-extended immediate, PC+4.
- `ex_flush`  in  1  — a taken branch or jr was resolved in EX this cycle.
- `ex_*`  out  —  registered copies of every `id_*` input above except `id_RegDst`.
- `ex_dest`  out  REG_W  — resolved destination register: `id_RegDst ? id_rt : id_rd`, registered.
- `hazard_stall`  out  1  — combinational; holds the PC and IF/ID register this cycle.

## Operation
Hazard detection (combinational):
- `hazard_stall` = `ex_valid & ex_MemRead & id_valid & ~ex_flush & ex_dest≠0 & (ex_dest==id_rs | (uses_rt & ex_dest==id_rt))`.
- `uses_rt` = `~id_ALUsrc | id_MemWrite | (id_PCsrc==2'b10)`.

Register update, evaluated in priority order each rising edge:
1. `ex_flush` = 1: load a bubble. `hazard_stall` is 0 in this case.
2. `hazard_stall` = 1: load a bubble. Upstream holds, so the same ID instruction is presented again next cycle.
3. Otherwise: capture all `id_*` inputs and set `ex_valid` = `id_valid`.

Bubble definition:
- All `ex_*` outputs are 0, including `ex_valid`, `ex_PCsrc` = 00 and `ex_ALUop` = 00000.
- A bubble has no architectural effect.

With `id_valid` = 0, the captured control bits are forced to the bubble encoding regardless of the `id_*` control inputs.

## Timing
- Reset: every `ex_*` output is 0 asynchronously. `hazard_stall` is 0 while `rst` is high.
- Latency: an `id_*` value presented at edge N appears on `ex_*` after edge N.
- Stall length: exactly one cycle per load-use pair. After the bubble, `ex_MemRead` = 0, so the stall cannot repeat on that pair.
- Back-to-back loads into a dependent instruction: the second load still stalls its own consumer. The detector depends only on current EX contents.
- `ex_flush` and a hazard in the same cycle: flush wins and there is no stall.
- `rst` asserted mid-stall: the register clears immediately and the stall request drops.

## Configuration
Macro `ID_EX_PERF_CNT_EN`.

Defined:
- Adds outputs `perf_stall_cnt` and `perf_flush_cnt`, 32 bits each, both reset to 0.
- `perf_stall_cnt` increments on every edge where `hazard_stall` = 1.
- `perf_flush_cnt` increments on every edge where `ex_flush` = 1.
- Both wrap from 0xFFFFFFFF to 0.

Undefined: the ports and logic are absent, and the behaviour of the block is otherwise identical.

## Test plan
- Reset release, then `addi` captured (`id_RegWrite`=1, `id_ALUsrc`=1, `id_RegDst`=1, `id_rt`=8, `id_imm`=5) → one edge later `ex_dest`=8, `ex_imm`=5, `ex_valid`=1.
- `lw` with `rt`=9 in EX, then `add` in ID with `id_rs`=9 → `hazard_stall`=1 for one cycle and a bubble enters EX. Next cycle `hazard_stall`=0 and `add` is captured.
- `lw` writing `$0` in EX, then consumer of `$0` in ID → `hazard_stall`=0.
- `lw` with `rt`=10 in EX, then `addi` in ID with `id_rt`=10 and `id_rs`=3 (`uses_rt`=0) → no stall. A `sw` in ID with `id_rt`=10 instead → stall.
- `ex_flush`=1 while a load-use hazard is present → `hazard_stall`=0 and EX receives a bubble (`ex_RegWrite`=0, `ex_MemWrite`=0, `ex_valid`=0).
- With `ID_EX_PERF_CNT_EN` defined: 3 stalls and 2 flushes → `perf_stall_cnt`=3, `perf_flush_cnt`=2. Assert `rst` → both counters read 0.
